shift_add_mult_ctrl: RTL and testbench
======================================

Name: shift_add_mult_ctrl

Overview:
- Sequencer and accumulator for the shift-add multiplier, directly downstream of the multiplier shift register.
- Consumes the shift register's contents and LSB, and drives its load, clear, shift and serial-in controls.
- Holds the high half of the product in its own accumulator.
- Combines both halves into the final product and signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, multiplicand/multiplier width; product is 2*WIDTH bits.
- CNT_W, 4, width of the step counter and of the ld_count input.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  begin a multiply; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE and clear the shift register.
- mcand  in  WIDTH  multiplicand; captured in LOAD.
- ld_count  in  CNT_W  number of steps, tied to the shift register's count output (8).
- mplr_q  in  WIDTH  shift register data_out; bit 0 is the current multiplier LSB.
- sr_ld  out  1  load strobe to the shift register.
- sr_clr  out  1  synchronous clear strobe to the shift register.
- sr_sft  out  1  shift-right strobe to the shift register.
- sr_sin  out  1  serial-in bit to the shift register, i.e. the accumulator LSB.
- product  out  2*WIDTH  {acc[WIDTH-1:0], mplr_q}; valid while done is high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (clr_n low, async): state=IDLE; acc (WIDTH+1 bits incl. carry)=0; mcand_r=0; cnt=0.
- Reset outputs: sr_ld=sr_clr=sr_sft=sr_sin=0, busy=0, done=0, product={0, mplr_q}.
- Reset is legal mid-operation; the shift register's own contents are not touched.
- All strobes are registered and decoded from state, one-hot per cycle.
- IDLE:
  - start=1 -> LOAD.
  - abort has priority over start -> sr_clr=1 for one cycle, stay IDLE.
- LOAD (1 cycle):
  - sr_ld=1; acc<=0; mcand_r<=mcand; cnt<=ld_count.
  - If ld_count==0 -> DONE, product={0, loaded multiplier}. Otherwise -> ADD.
- ADD (1 cycle):
  - If mplr_q[0]==1, acc <= {1'b0, acc[WIDTH-1:0]} + mcand_r, full WIDTH+1-bit result with carry kept in acc[WIDTH]. Else acc is unchanged.
  - -> SHIFT.
- SHIFT (1 cycle):
  - sr_sft=1; sr_sin=acc[0]; acc <= {1'b0, acc[WIDTH:1]}; cnt<=cnt-1.
  - cnt==1 before decrement -> DONE, else -> ADD.
- DONE (1 cycle):
  - done=1, busy=1, product valid.
  - -> IDLE. start is ignored in DONE.
- Latency: done is high exactly 2*ld_count+2 clocks after the edge that samples start (18 for ld_count=8).
- start while busy: ignored.
- abort while busy, any state: next state IDLE; sr_clr=1 that cycle; acc<=0; done never asserts for the aborted operation.
- abort and the final SHIFT->DONE transition in the same cycle: abort wins.
- No overflow is possible: acc carries WIDTH+1 bits, and the product of two WIDTH-bit values fits in 2*WIDTH bits.

Optional Feature:
- Macro: FUSED_STEP_EN.
- Defined:
  - ADD and SHIFT merge into a single STEP state.
  - sum = {1'b0, acc[WIDTH-1:0]} + (mplr_q[0] ? mcand_r : 0).
  - acc <= sum>>1; sr_sin=sum[0]; sr_sft=1; cnt decrements each STEP.
  - Latency becomes ld_count+2 clocks (10 for 8).
- Undefined: two-state ADD/SHIFT behaviour as above.
- Products are identical in both builds.

Test Plan:
- Reset then mcand=13, multiplier=11, start pulse -> done high 18 clocks later (10 with FUSED_STEP_EN); product=0x008F; busy low the following cycle.
- mcand=255, multiplier=255 -> product=0xFE01; exercises the carry into acc[WIDTH] on every add step.
- mcand=0x5A, multiplier=0 -> product=0x0000; sr_sft pulses exactly 8 times and sr_ld exactly once.
- start re-asserted on cycles 3 and 10 of a running 13x11 multiply -> no restart; a single done; product=0x008F.
- abort asserted 5 cycles after start -> sr_clr pulses once; state IDLE next cycle; done never asserts; a following 7x6 multiply gives 0x002A.
- clr_n dropped asynchronously mid-multiply -> busy/done/strobes 0 immediately; after release, 3x5 gives 0x000F.

Source files
------------

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer and high-half accumulator for a shift-add multiplier driving an external shift register.
// Define FUSED_STEP_EN to merge the add and shift phases into one STEP state per multiplier bit.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [CNT_W-1:0]     ld_count,
    input  logic [WIDTH-1:0]     mplr_q,
    output logic                 sr_ld,
    output logic                 sr_clr,
    output logic                 sr_sft,
    output logic                 sr_sin,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

`ifdef FUSED_STEP_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADD, S_SHIFT, S_DONE} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH:0]   acc_reg, acc_next, sum;
    logic [WIDTH-1:0] mcand_reg, addend;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             clr_reg;

    // acc_reg[WIDTH] is always clear whenever sum is consumed (after LOAD or a shift),
    // so this equals adding to the low WIDTH bits with the carry landing in bit WIDTH.
    assign addend  = mplr_q[0] ? mcand_reg : '0;
    assign sum     = acc_reg + {1'b0, addend};
    assign product = {acc_reg[WIDTH-1:0], mplr_q};
    assign sr_clr  = clr_reg;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sr_ld      = 1'b0;
        sr_sft     = 1'b0;
        sr_sin     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                sr_ld    = 1'b1;
                acc_next = '0;
                cnt_next = ld_count;
`ifdef FUSED_STEP_EN
                state_next = (ld_count == '0) ? S_DONE : S_STEP;
`else
                state_next = (ld_count == '0) ? S_DONE : S_ADD;
`endif
            end
`ifdef FUSED_STEP_EN
            S_STEP: begin
                sr_sft     = 1'b1;
                sr_sin     = sum[0];
                acc_next   = {1'b0, sum[WIDTH:1]};
                cnt_next   = cnt_reg - CNT_W'(1);
                state_next = (cnt_reg == CNT_W'(1)) ? S_DONE : S_STEP;
            end
`else
            S_ADD: begin
                acc_next   = sum;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                sr_sft     = 1'b1;
                sr_sin     = acc_reg[0];
                acc_next   = {1'b0, acc_reg[WIDTH:1]};
                cnt_next   = cnt_reg - CNT_W'(1);
                state_next = (cnt_reg == CNT_W'(1)) ? S_DONE : S_ADD;
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // abort overrides every transition, including the final step into DONE
        if (abort) begin
            state_next = S_IDLE;
            acc_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            mcand_reg <= '0;
            cnt_reg   <= '0;
            clr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            clr_reg   <= abort;
            if (state_reg == S_LOAD) mcand_reg <= mcand;
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl with a behavioural model of the attached shift register.
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start, abort;
    logic [7:0]  mcand;
    logic [3:0]  ld_count;
    logic [7:0]  mplr_q;
    logic        sr_ld, sr_clr, sr_sft, sr_sin;
    logic [15:0] product;
    logic        busy, done;

    logic [7:0]  mplr_load;
    logic [7:0]  sr = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .abort    (abort),
        .mcand    (mcand),
        .ld_count (ld_count),
        .mplr_q   (mplr_q),
        .sr_ld    (sr_ld),
        .sr_clr   (sr_clr),
        .sr_sft   (sr_sft),
        .sr_sin   (sr_sin),
        .product  (product),
        .busy     (busy),
        .done     (done)
    );

    // Shift register model; it has no connection to clr_n.
    always @(posedge clk) begin
        if (sr_clr)      sr <= 8'h00;
        else if (sr_ld)  sr <= mplr_load;
        else if (sr_sft) sr <= {sr_sin, sr[7:1]};
    end
    assign mplr_q = sr;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  n;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // After n steps {acc, sr} holds the low n multiplier bits times mcand, aligned above the untouched bits.
    function automatic logic [15:0] model_product(input logic [7:0] a, input logic [7:0] b, input int n);
        int unsigned lowb;
        int unsigned p;
        lowb = int'(b) & ((1 << n) - 1);
        p = (int'(b) >> n) + ((int'(a) * lowb) << (8 - n));
        return 16'(p);
    endfunction

    function automatic int model_latency(input int n);
`ifdef FUSED_STEP_EN
        return n + 2;
`else
        return 2 * n + 2;
`endif
    endfunction

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic [3:0] n,
                            input logic [15:0] exp, input bit restart, input string tag);
        int lat, first_done, done_cnt, ld_cnt, sft_cnt, hot_viol;
        logic [15:0] prod_at_done;
        logic busy_at_done, busy_after;
        lat = model_latency(int'(n));
        first_done = -1; done_cnt = 0; ld_cnt = 0; sft_cnt = 0; hot_viol = 0;
        prod_at_done = '0; busy_at_done = 1'b0; busy_after = 1'b1;
        @(negedge clk);
        mcand = a; mplr_load = b; ld_count = n; start = 1'b1;
        for (int k = 1; k <= lat + 4; k++) begin
            @(negedge clk);
            start = restart && (k == 3 || k == 10);
            ld_cnt  += int'(sr_ld);
            sft_cnt += int'(sr_sft);
            if (int'(sr_ld) + int'(sr_sft) + int'(sr_clr) > 1) hot_viol++;
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done   = k;
                    prod_at_done = product;
                    busy_at_done = busy;
                end
            end
            if (first_done > 0 && k == first_done + 1) busy_after = busy;
        end
        start = 1'b0;
        check({tag, "_latency"},   32'(first_done), 32'(lat));
        check({tag, "_product"},   32'(prod_at_done), 32'(exp));
        check({tag, "_done_cnt"},  32'(done_cnt), 32'd1);
        check({tag, "_ld_cnt"},    32'(ld_cnt), 32'd1);
        check({tag, "_sft_cnt"},   32'(sft_cnt), 32'(n));
        check({tag, "_onehot"},    32'(hot_viol), 32'd0);
        check({tag, "_busy_done"}, 32'(busy_at_done), 32'd1);
        check({tag, "_busy_next"}, 32'(busy_after), 32'd0);
        $display("txn %s: a=%02h b=%02h n=%0d product=%04h expected=%04h latency=%0d",
                 tag, a, b, n, prod_at_done, exp, first_done);
    endtask

    vec_t tbl[6];

    initial begin
        int clr_cnt, done_cnt;
        logic [7:0] a, b;
        logic [3:0] n;

        tbl[0] = '{a: 8'd13,  b: 8'd11,  n: 4'd8, exp: 16'h008F};
        tbl[1] = '{a: 8'd255, b: 8'd255, n: 4'd8, exp: 16'hFE01};
        tbl[2] = '{a: 8'h5A,  b: 8'h00,  n: 4'd8, exp: 16'h0000};
        tbl[3] = '{a: 8'd7,   b: 8'd6,   n: 4'd8, exp: 16'h002A};
        tbl[4] = '{a: 8'hB3,  b: 8'h2C,  n: 4'd0, exp: 16'h002C};
        tbl[5] = '{a: 8'h0F,  b: 8'hA5,  n: 4'd4, exp: 16'h04BA};

        clr_n = 1'b0; start = 1'b0; abort = 1'b0;
        mcand = 8'h00; ld_count = 4'd8; mplr_load = 8'h00;
        #3;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_strobes", {28'd0, sr_ld, sr_clr, sr_sft, sr_sin}, 32'd0);
        check("reset_product", 32'(product), 32'h0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_mult(tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));

        run_mult(8'd13, 8'd11, 4'd8, 16'h008F, 1'b1, "restart");

        // abort five cycles into a multiply
        clr_cnt = 0; done_cnt = 0;
        @(negedge clk);
        mcand = 8'd13; mplr_load = 8'd11; ld_count = 4'd8; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            clr_cnt  += int'(sr_clr);
            done_cnt += int'(done);
            if (k == 5) abort = 1'b1;
            if (k == 6) begin
                abort = 1'b0;
                check("abort_idle", 32'(busy), 32'd0);
                check("abort_clr", 32'(sr_clr), 32'd1);
            end
        end
        check("abort_clr_cnt", 32'(clr_cnt), 32'd1);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        $display("txn abort: clr_pulses=%0d done_pulses=%0d", clr_cnt, done_cnt);
        run_mult(8'd7, 8'd6, 4'd8, 16'h002A, 1'b0, "after_abort");

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        mcand = 8'd13; mplr_load = 8'd11; ld_count = 4'd8; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 clr_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_strobes", {28'd0, sr_ld, sr_clr, sr_sft, sr_sin}, 32'd0);
        check("midrst_product", 32'(product), {16'd0, 8'h00, sr});
        $display("txn midreset: busy=%0b product=%04h", busy, product);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        run_mult(8'd3, 8'd5, 4'd8, 16'h000F, 1'b0, "after_reset");

        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            n = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 8)) : 4'd8;
            run_mult(a, b, n, model_product(a, b, int'(n)), 1'b0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
